calc_entry_fsm: RTL and testbench

Operand-entry controller for the calculator datapath. It debounces the front-panel buttons and steps through three phases: enter operand A, enter operand B, and show result. It latches the switch value as each operand and drives the one-hot display-source enables `en1`/`en2`/`en3` that the display source mux consumes. It also issues a single-cycle `calc_start` to the ALU when operand B is committed.

---
 rtl/calc_entry_fsm.sv | 127 ++++++++++++
 tb/tb_calc_entry_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// Operand-entry controller: synchronizes and debounces the next/clear buttons,
// latches two operands from the switches and sequences the display-source enables.
module calc_entry_fsm #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next_raw,
  input  logic             btn_clear_raw,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             calc_start,
  output logic             en1,
  output logic             en2,
  output logic             en3
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    SHOW_RES = 2'd2
  } state_e;

  // Button index 0 is next, index 1 is clear.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       level_q, level_d;
  logic [1:0]       prev_q;
  logic [1:0]       press;
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [WIDTH-1:0] sw_sync1_q, sw_sync2_q;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             calc_start_q, calc_start_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case leaves a signal unassigned and infers a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign press = level_q & ~prev_q;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    calc_start_d = 1'b0;
    // Clear dominates a coincident next event.
    if (press[1]) begin
      state_d = ENTER_A;
      op_a_d  = '0;
      op_b_d  = '0;
    end else begin
      case (state_q)
        ENTER_A: if (press[0]) begin
          op_a_d  = sw_sync2_q;
          state_d = ENTER_B;
        end
        ENTER_B: if (press[0]) begin
          op_b_d       = sw_sync2_q;
          calc_start_d = 1'b1;
          state_d      = SHOW_RES;
        end
        SHOW_RES: if (press[0]) state_d = ENTER_A;
        default: state_d = ENTER_A;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, giving the intended pipeline ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      prev_q       <= '0;
      // NOTE: the counter array is control state, not storage, so it is reset.
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      sw_sync1_q   <= '0;
      sw_sync2_q   <= '0;
      state_q      <= ENTER_A;
      op_a_q       <= '0;
      op_b_q       <= '0;
      calc_start_q <= 1'b0;
    end else begin
      sync1_q      <= {btn_clear_raw, btn_next_raw};
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      prev_q       <= level_q;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      sw_sync1_q   <= sw;
      sw_sync2_q   <= sw_sync1_q;
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      calc_start_q <= calc_start_d;
    end
  end

  assign operand_a  = op_a_q;
  assign operand_b  = op_b_q;
  assign calc_start = calc_start_q;
  assign en1        = (state_q == ENTER_A);
  assign en2        = (state_q == ENTER_B);
  assign en3        = (state_q == SHOW_RES);

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm: a cycle-level reference model publishes
// each expected output change with its cycle; a monitor matches DUT changes.
module tb_calc_entry_fsm;

  localparam int W  = 6;
  localparam int D  = 4;
  localparam int HL = D + 3;
  localparam int VW = 2 * W + 4;
  localparam logic [VW-1:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b0, {(2 * W){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_next_raw = 1'b0;
  logic         btn_clear_raw = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] operand_a, operand_b;
  logic         calc_start, en1, en2, en3;

  calc_entry_fsm #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_next_raw (btn_next_raw),
    .btn_clear_raw(btn_clear_raw),
    .sw           (sw),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .calc_start   (calc_start),
    .en1          (en1),
    .en2          (en2),
    .en3          (en3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp,
                       input int acyc, input int ecyc);
    checks++;
    if (act !== exp || acyc != ecyc) begin
      fails++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", name, act, acyc, exp, ecyc);
    end
  endtask

  // Reference model: a button level change is accepted once the raw input, seen
  // two edges late, has disagreed with the accepted level for D+1 samples in a row;
  // the press acts on the state one edge after acceptance.
  int           m_state;  // 0: entering A, 1: entering B, 2: showing result
  logic [W-1:0] m_a, m_b;
  logic         m_cs;
  bit           m_lvl  [2];
  bit           m_rose [2];
  bit           hist   [2][HL];
  logic [W-1:0] sw_h1, sw_h2;
  logic [VW-1:0] m_last = RST_VEC;

  task automatic m_publish(input int stamp);
    logic [VW-1:0] v;
    v = {m_state == 2, m_state == 1, m_state == 0, m_cs, m_b, m_a};
    if (v !== m_last) begin
      exp_q.push_back('{v, stamp});
      m_last = v;
    end
  endtask

  task automatic m_reset(input int stamp);
    m_state = 0;
    m_a = '0;
    m_b = '0;
    m_cs = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b]  = 1'b0;
      m_rose[b] = 1'b0;
      for (int i = 0; i < HL; i++) hist[b][i] = 1'b0;
    end
    sw_h1 = '0;
    sw_h2 = '0;
    m_publish(stamp);
  endtask

  task automatic m_step(input int stamp);
    bit nx, cl, all_differ;
    bit raw [2];
    nx = m_rose[0];
    cl = m_rose[1];
    m_cs = 1'b0;
    if (cl) begin
      m_state = 0;
      m_a = '0;
      m_b = '0;
    end else if (nx) begin
      if (m_state == 0) begin
        m_a = sw_h2;
        m_state = 1;
      end else if (m_state == 1) begin
        m_b = sw_h2;
        m_cs = 1'b1;
        m_state = 2;
      end else begin
        m_state = 0;
      end
    end
    raw[0] = btn_next_raw;
    raw[1] = btn_clear_raw;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < HL - 1; i++) hist[b][i] = hist[b][i + 1];
      hist[b][HL - 1] = raw[b];
      all_differ = 1'b1;
      for (int i = 0; i <= D; i++) if (hist[b][i] == m_lvl[b]) all_differ = 1'b0;
      m_rose[b] = 1'b0;
      if (all_differ) begin
        m_rose[b] = !m_lvl[b];
        m_lvl[b]  = !m_lvl[b];
      end
    end
    sw_h2 = sw_h1;
    sw_h1 = sw;
    m_publish(stamp);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset(cyc);
    else        m_step(cyc + 1);
  end

  // Monitor: any change of the observable outputs must match the next expected entry.
  logic [VW-1:0] mon_last = RST_VEC;
  always @(negedge clk) begin
    logic [VW-1:0] cur;
    exp_t e;
    cur = {en3, en2, en1, calc_start, operand_b, operand_a};
    if (cur !== mon_last) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", cur, mon_last, cyc, cyc);
      end else begin
        e = exp_q.pop_front();
        check("output_change", cur, e.vec, cyc, e.cyc);
      end
      mon_last = cur;
    end
  end

  // Called at one time unit after a rising edge; holds the buttons for n edges.
  task automatic hold(input bit nx, input bit cl, input int n);
    btn_next_raw  = nx;
    btn_clear_raw = cl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit bounce [6];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {en3, en2, en1, calc_start, operand_b, operand_a}, RST_VEC, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full A -> B -> result -> A sequence.
    sw = 6'd23; hold(1, 0, 20); hold(0, 0, 10);
    sw = 6'd41; hold(1, 0, 20); hold(0, 0, 10);
    hold(1, 0, 20); hold(0, 0, 10);

    // Bounce then steady press.
    for (int i = 0; i < 6; i++) hold(bounce[i], 0, 1);
    hold(1, 0, 10); hold(0, 0, 10);

    // Long hold gives one event; a fresh press gives another.
    hold(1, 0, 200); hold(0, 0, 10);
    hold(1, 0, 20); hold(0, 0, 10);

    // Reach the result phase, then clear.
    sw = 6'd17; hold(1, 0, 20); hold(0, 0, 10);
    sw = 6'd9;  hold(1, 0, 20); hold(0, 0, 10);
    hold(0, 1, 20); hold(0, 0, 10);

    // Enter B, then next and clear rise together.
    sw = 6'd55; hold(1, 0, 20); hold(0, 0, 10);
    sw = 6'd33; hold(1, 1, 20); hold(0, 0, 10);

    // Async reset while the next press is mid-debounce, button kept held.
    sw = 6'd12;
    hold(1, 0, 4);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hold(1, 0, 20); hold(0, 0, 10);

    // Randomized bursts, including bounces and occasional clears.
    for (int k = 0; k < 60; k++) begin
      sw = W'($urandom);
      hold(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), $urandom_range(1, 12));
    end
    hold(0, 0, 30);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_expected: got %0d unmatched changes, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
